// File: rtl/nivel2_temporizador.sv
// Cooking timer: holds MM:SS as four BCD digits loaded from the keypad and counts
// down one second per TICKS_PER_SEC clocks while the magnetron is on.
module nivel2_temporizador #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       magnetron_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        EMPTY,
        SET,
        RUN
    } state_t;

    state_t        r_state;
    logic [3:0]    r_minTens, r_minUnits, r_secTens, r_secUnits;
    logic [PW-1:0] r_presc;
    logic          r_timerDone;
    logic          r_donePulse;

    logic          w_keyAccept;
    logic          w_count;
    logic          w_tick;
    logic [3:0]    w_decMinTens, w_decMinUnits, w_decSecTens, w_decSecUnits;
    logic [3:0]    w_nextMinTens, w_nextMinUnits, w_nextSecTens, w_nextSecUnits;
    logic [PW-1:0] w_nextPresc;
    logic          w_nextZero;

    // EMPTY is held exactly when the stored time is 00:00, so the state doubles as the nonzero flag.
    assign w_keyAccept = key_valid && (key_digit <= 4'd9) && !magnetron_on;
    assign w_count     = magnetron_on && (r_state != EMPTY);
    assign w_tick      = w_count && (r_presc == PRESC_LAST);

    always_comb begin
        w_decMinTens  = r_minTens;
        w_decMinUnits = r_minUnits;
        w_decSecTens  = r_secTens;
        w_decSecUnits = r_secUnits;
        if (r_secUnits != 4'd0) begin
            w_decSecUnits = r_secUnits - 4'd1;
        end else if (r_secTens != 4'd0) begin
            w_decSecUnits = 4'd9;
            w_decSecTens  = r_secTens - 4'd1;
        end else begin
            // Only reached with nonzero minutes, since ticks never fire at 00:00.
            w_decSecUnits = 4'd9;
            w_decSecTens  = 4'd5;
            if (r_minUnits != 4'd0) begin
                w_decMinUnits = r_minUnits - 4'd1;
            end else begin
                w_decMinUnits = 4'd9;
                w_decMinTens  = r_minTens - 4'd1;
            end
        end
    end

    always_comb begin
        w_nextMinTens  = r_minTens;
        w_nextMinUnits = r_minUnits;
        w_nextSecTens  = r_secTens;
        w_nextSecUnits = r_secUnits;
        w_nextPresc    = r_presc;
        if (clear) begin
            w_nextMinTens  = 4'd0;
            w_nextMinUnits = 4'd0;
            w_nextSecTens  = 4'd0;
            w_nextSecUnits = 4'd0;
            w_nextPresc    = '0;
        end else if (w_keyAccept) begin
            w_nextMinTens  = r_minUnits;
            w_nextMinUnits = r_secTens;
            w_nextSecTens  = r_secUnits;
            w_nextSecUnits = key_digit;
            w_nextPresc    = '0;
        end else if (w_tick) begin
            w_nextMinTens  = w_decMinTens;
            w_nextMinUnits = w_decMinUnits;
            w_nextSecTens  = w_decSecTens;
            w_nextSecUnits = w_decSecUnits;
            w_nextPresc    = '0;
        end else if (w_count) begin
            w_nextPresc    = r_presc + 1'b1;
        end
    end

    assign w_nextZero = (w_nextMinTens == 4'd0) && (w_nextMinUnits == 4'd0) &&
                        (w_nextSecTens == 4'd0) && (w_nextSecUnits == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_minTens   <= 4'd0;
            r_minUnits  <= 4'd0;
            r_secTens   <= 4'd0;
            r_secUnits  <= 4'd0;
            r_presc     <= '0;
            r_timerDone <= 1'b1;
            r_donePulse <= 1'b0;
        end else begin
            r_minTens   <= w_nextMinTens;
            r_minUnits  <= w_nextMinUnits;
            r_secTens   <= w_nextSecTens;
            r_secUnits  <= w_nextSecUnits;
            r_presc     <= w_nextPresc;
            r_timerDone <= w_nextZero;
            r_donePulse <= !clear && w_tick && w_nextZero;
            if (w_nextZero) begin
                r_state <= EMPTY;
            end else if (magnetron_on) begin
                r_state <= RUN;
            end else begin
                r_state <= SET;
            end
        end
    end

    assign min_tens   = r_minTens;
    assign min_units  = r_minUnits;
    assign sec_tens   = r_secTens;
    assign sec_units  = r_secUnits;
    assign timer_done = r_timerDone;
    assign done_pulse = r_donePulse;

endmodule

// File: tb/tb_nivel2_temporizador.sv
// Scoreboard bench for nivel2_temporizador: the driver pushes the expected
// display per clock, a separate monitor pops and compares one cycle's output.
module tb_nivel2_temporizador;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       magnetron_on;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       timer_done;
    logic       done_pulse;

    typedef struct packed {
        logic [15:0] digits;
        logic        done;
        logic        pulse;
    } exp_t;

    exp_t  q[$];
    int    nChecks = 0;
    int    nFails  = 0;
    string phase   = "reset";

    // The model keeps the display as a plain 4-digit decimal number MMSS.
    int    mDisp  = 0;
    int    mPresc = 0;

    nivel2_temporizador #(.TICKS_PER_SEC(TPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .magnetron_on (magnetron_on),
        .min_tens     (min_tens),
        .min_units    (min_units),
        .sec_tens     (sec_tens),
        .sec_units    (sec_units),
        .timer_done   (timer_done),
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int decSecond(input int v);
        int mm = v / 100;
        int ss = v % 100;
        if (ss > 0) return v - 1;
        return (mm - 1) * 100 + 59;
    endfunction

    function automatic exp_t sampleDut();
        exp_t g;
        g.digits = {min_tens, min_units, sec_tens, sec_units};
        g.done   = timer_done;
        g.pulse  = done_pulse;
        return g;
    endfunction

    task automatic checkOutput(input string name, input exp_t got, input exp_t exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s @%0t: got digits=%h done=%b pulse=%b, expected digits=%h done=%b pulse=%b",
                     name, $time, got.digits, got.done, got.pulse, exp.digits, exp.done, exp.pulse);
        end
    endtask

    task automatic applyStimulus(input bit c, input bit kv, input logic [3:0] kd, input bit m);
        exp_t e;
        bit   pulse;
        @(negedge clk);
        clear        = c;
        key_valid    = kv;
        key_digit    = kd;
        magnetron_on = m;
        pulse = 1'b0;
        if (c) begin
            mDisp  = 0;
            mPresc = 0;
        end else if (kv && kd <= 9 && !m) begin
            mDisp  = (mDisp * 10 + int'(kd)) % 10000;
            mPresc = 0;
        end else if (m && mDisp != 0) begin
            if (mPresc == TPS - 1) begin
                mPresc = 0;
                mDisp  = decSecond(mDisp);
                pulse  = (mDisp == 0);
            end else begin
                mPresc++;
            end
        end
        e.digits = toBcd(mDisp);
        e.done   = (mDisp == 0);
        e.pulse  = pulse;
        q.push_back(e);
    endtask

    task automatic pressKey(input logic [3:0] d);
        applyStimulus(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic runCycles(input int n, input bit m);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, m);
    endtask

    task automatic doClear();
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic asyncReset();
        exp_t e;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        e.digits = 16'h0000;
        e.done   = 1'b1;
        e.pulse  = 1'b0;
        checkOutput("async_reset", sampleDut(), e);
        #1 rst = 1'b0;
        mDisp  = 0;
        mPresc = 0;
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checkOutput(phase, sampleDut(), e);
            end
        end
    end

    initial begin
        exp_t e;
        rst          = 1'b1;
        clear        = 1'b0;
        key_valid    = 1'b0;
        key_digit    = 4'd0;
        magnetron_on = 1'b0;
        #12;
        e.digits = 16'h0000;
        e.done   = 1'b1;
        e.pulse  = 1'b0;
        checkOutput("reset_state", sampleDut(), e);
        #1 rst = 1'b0;

        phase = "load";
        pressKey(4'd1); pressKey(4'd3); pressKey(4'd0);
        pressKey(4'd12);
        runCycles(2, 1'b0);

        phase = "count";
        doClear();
        pressKey(4'd2);
        runCycles(14, 1'b1);

        phase = "borrow_min";
        doClear();
        pressKey(4'd1); pressKey(4'd0); pressKey(4'd0);
        runCycles(5, 1'b1);

        phase = "borrow_090";
        doClear();
        pressKey(4'd9); pressKey(4'd0);
        runCycles(5, 1'b1);

        phase = "borrow_1000";
        doClear();
        pressKey(4'd1); pressKey(4'd0); pressKey(4'd0); pressKey(4'd0);
        runCycles(5, 1'b1);

        phase = "pause";
        doClear();
        pressKey(4'd3);
        runCycles(2, 1'b1);
        runCycles(10, 1'b0);
        runCycles(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
        runCycles(10, 1'b1);

        phase = "clear_prio";
        doClear();
        pressKey(4'd4); pressKey(4'd5);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);
        runCycles(3, 1'b0);

        phase = "reset_mid_run";
        doClear();
        pressKey(4'd5); pressKey(4'd0);
        runCycles(7, 1'b1);
        asyncReset();
        runCycles(3, 1'b0);

        phase = "random";
        begin
            bit m = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                bit c  = ($urandom_range(0, 39) == 0);
                bit kv = ($urandom_range(0, 3) == 0);
                logic [3:0] kd = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 11) == 0) m = ~m;
                applyStimulus(c, kv, kd, m);
            end
        end

        phase = "drain";
        repeat (3) @(posedge clk);
        #2;
        nChecks++;
        if (q.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
